// File: rtl/alu_operand_sel.sv
// ALU operand-select stage: NUM_CH-way source mux with narrow-channel extension,
// registered behind a valid/ready handshake. Optional feature macro: ALU_OPSEL_SEXT_EN (adds sext_i).

module alu_operand_sel_chan #(
    parameter int DATA_W    = 32,
    parameter int NARROW_W  = 6,
    parameter bit IS_NARROW = 1'b0
) (
    input  logic [DATA_W-1:0] slot_i,
    input  logic              sext_i,
    output logic [DATA_W-1:0] opnd_o
);
    generate
        if (IS_NARROW) begin : g_narrow
            logic fill;
            logic unused_hi;
            assign fill      = sext_i & slot_i[NARROW_W-1];
            assign opnd_o    = {{(DATA_W-NARROW_W){fill}}, slot_i[NARROW_W-1:0]};
            // Upper slot bits carry no meaning for the narrow channel.
            assign unused_hi = ^slot_i[DATA_W-1:NARROW_W];
        end else begin : g_wide
            logic unused_sext;
            assign opnd_o      = slot_i;
            assign unused_sext = sext_i;
        end
    endgenerate
endmodule

module alu_operand_sel #(
    parameter int DATA_W    = 32,
    parameter int NUM_CH    = 4,
    parameter int SEL_W     = 2,
    parameter int NARROW_CH = 2,
    parameter int NARROW_W  = 6,
    parameter int CNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [SEL_W-1:0]         sel_i,
`ifdef ALU_OPSEL_SEXT_EN
    input  logic                     sext_i,
`endif
    input  logic [NUM_CH*DATA_W-1:0] data_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     sel_err_o,
    output logic [CNT_W-1:0]         stall_cnt_o
);
    logic                           sext;
    logic [NUM_CH-1:0][DATA_W-1:0]  opnd;

    logic                           out_valid_q, out_valid_d;
    logic [DATA_W-1:0]              data_q, data_d;
    logic                           sel_err_q, sel_err_d;
    logic [CNT_W-1:0]               stall_cnt_q, stall_cnt_d;

    logic                           accept;
    logic                           sel_ok;
    logic [DATA_W-1:0]              mux;

`ifdef ALU_OPSEL_SEXT_EN
    assign sext = sext_i;
`else
    assign sext = 1'b0;
`endif

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
            alu_operand_sel_chan #(
                .DATA_W    (DATA_W),
                .NARROW_W  (NARROW_W),
                .IS_NARROW (k == NARROW_CH)
            ) u_chan (
                .slot_i (data_i[k*DATA_W +: DATA_W]),
                .sext_i (sext),
                .opnd_o (opnd[k])
            );
        end
    endgenerate

    assign in_ready_o  = !out_valid_q || out_ready_i;
    assign accept      = in_valid_i && in_ready_o;

    always_comb begin
        sel_ok = ({1'b0, sel_i} < (SEL_W+1)'(NUM_CH));
        mux    = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel_i == SEL_W'(k)) mux = opnd[k];
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        data_d      = data_q;
        sel_err_d   = sel_err_q;
        stall_cnt_d = stall_cnt_q;
        // A same-cycle consume and accept simply overwrites the held operand.
        if (accept) begin
            out_valid_d = 1'b1;
            data_d      = sel_ok ? mux : '0;
            if (!sel_ok) sel_err_d = 1'b1;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
        if (out_valid_q && !out_ready_i && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            data_q      <= '0;
            sel_err_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            data_q      <= data_d;
            sel_err_q   <= sel_err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign data_o      = data_q;
    assign sel_err_o   = sel_err_q;
    assign stall_cnt_o = stall_cnt_q;
endmodule

// File: tb/tb_alu_operand_sel.sv
// Directed bench: default instance for sweep/back-pressure, a NUM_CH=3/CNT_W=4 instance
// for illegal-select and saturation corner cases.

module tb_alu_operand_sel;
    localparam logic [31:0] CH0 = 32'h1111_1111;
    localparam logic [31:0] CH1 = 32'h0040_0000;
    localparam logic [31:0] CH2 = 32'hFFFF_FFE5;
    localparam logic [31:0] CH3 = 32'hDEAD_BEEF;

    logic         clk = 1'b0;
    logic         reset;

    logic         in_valid, out_ready;
    logic [1:0]   sel;
    logic [127:0] data;
    logic         in_ready, out_valid, sel_err;
    logic [31:0]  data_o;
    logic [15:0]  stall_cnt;
`ifdef ALU_OPSEL_SEXT_EN
    logic         sext;
`endif

    logic         in_valid2, out_ready2;
    logic [1:0]   sel2;
    logic [95:0]  data2;
    logic         in_ready2, out_valid2, sel_err2;
    logic [31:0]  data_o2;
    logic [3:0]   stall_cnt2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_operand_sel u_dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .sel_i       (sel),
`ifdef ALU_OPSEL_SEXT_EN
        .sext_i      (sext),
`endif
        .data_i      (data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .data_o      (data_o),
        .sel_err_o   (sel_err),
        .stall_cnt_o (stall_cnt)
    );

    alu_operand_sel #(.NUM_CH(3), .SEL_W(2), .CNT_W(4)) u_dut3 (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (in_valid2),
        .in_ready_o  (in_ready2),
        .sel_i       (sel2),
`ifdef ALU_OPSEL_SEXT_EN
        .sext_i      (1'b0),
`endif
        .data_i      (data2),
        .out_valid_o (out_valid2),
        .out_ready_i (out_ready2),
        .data_o      (data_o2),
        .sel_err_o   (sel_err2),
        .stall_cnt_o (stall_cnt2)
    );

    typedef struct {
        logic        v;
        logic [1:0]  sel;
        logic        rdy;
        logic        scr;
        logic [31:0] e_data;
        logic        e_vld;
        logic        e_irdy;
        logic [15:0] e_stall;
    } vec_t;

    vec_t tbl[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        tbl[0]  = '{1'b1, 2'd0, 1'b1, 1'b0, CH0,          1'b1, 1'b1, 16'd0};
        tbl[1]  = '{1'b1, 2'd1, 1'b1, 1'b0, CH1,          1'b1, 1'b1, 16'd0};
        tbl[2]  = '{1'b1, 2'd2, 1'b1, 1'b0, 32'h0000_0025, 1'b1, 1'b1, 16'd0};
        tbl[3]  = '{1'b1, 2'd3, 1'b1, 1'b0, CH3,          1'b1, 1'b1, 16'd0};
        tbl[4]  = '{1'b1, 2'd0, 1'b0, 1'b1, CH3,          1'b1, 1'b0, 16'd1};
        tbl[5]  = '{1'b1, 2'd1, 1'b0, 1'b1, CH3,          1'b1, 1'b0, 16'd2};
        tbl[6]  = '{1'b1, 2'd2, 1'b0, 1'b1, CH3,          1'b1, 1'b0, 16'd3};
        tbl[7]  = '{1'b1, 2'd0, 1'b0, 1'b1, CH3,          1'b1, 1'b0, 16'd4};
        tbl[8]  = '{1'b1, 2'd1, 1'b0, 1'b1, CH3,          1'b1, 1'b0, 16'd5};
        tbl[9]  = '{1'b1, 2'd0, 1'b1, 1'b0, CH0,          1'b1, 1'b1, 16'd5};
        tbl[10] = '{1'b0, 2'd3, 1'b1, 1'b0, CH0,          1'b0, 1'b1, 16'd5};
        tbl[11] = '{1'b0, 2'd3, 1'b0, 1'b0, CH0,          1'b0, 1'b1, 16'd5};
        tbl[12] = '{1'b1, 2'd1, 1'b0, 1'b0, CH1,          1'b1, 1'b0, 16'd5};
        tbl[13] = '{1'b1, 2'd2, 1'b0, 1'b0, CH1,          1'b1, 1'b0, 16'd6};

        in_valid = 1'b0; out_ready = 1'b1; sel = 2'd0; data = {CH3, CH2, CH1, CH0};
`ifdef ALU_OPSEL_SEXT_EN
        sext = 1'b0;
`endif
        in_valid2 = 1'b0; out_ready2 = 1'b1; sel2 = 2'd3; data2 = {CH2, CH1, CH0};

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_valid",    {31'd0, out_valid}, 32'd0);
        chk("rst_data",     data_o,             32'd0);
        chk("rst_err",      {31'd0, sel_err},   32'd0);
        chk("rst_stall",    {16'd0, stall_cnt}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready},  32'd1);

        // Main sweep / back-pressure; the narrow instance idles with sel=3, in_valid=0.
        for (int i = 0; i < 14; i++) begin
            in_valid  = tbl[i].v;
            sel       = tbl[i].sel;
            out_ready = tbl[i].rdy;
            data      = tbl[i].scr ? {4{32'hA5A5_0000 | 32'(i)}} : {CH3, CH2, CH1, CH0};
            tick();
            chk($sformatf("v%0d_data", i),     data_o,             tbl[i].e_data);
            chk($sformatf("v%0d_valid", i),    {31'd0, out_valid}, {31'd0, tbl[i].e_vld});
            chk($sformatf("v%0d_in_ready", i), {31'd0, in_ready},  {31'd0, tbl[i].e_irdy});
            chk($sformatf("v%0d_stall", i),    {16'd0, stall_cnt}, {16'd0, tbl[i].e_stall});
            chk($sformatf("v%0d_err", i),      {31'd0, sel_err},   32'd0);
        end

        chk("idle_bad_sel_err", {31'd0, sel_err2},   32'd0);
        chk("idle_bad_sel_vld", {31'd0, out_valid2}, 32'd0);

        in_valid2 = 1'b1; sel2 = 2'd0;
        tick();
        chk("ill_s0_data", data_o2,            CH0);
        chk("ill_s0_err",  {31'd0, sel_err2},  32'd0);
        sel2 = 2'd3;
        tick();
        chk("ill_s3_data", data_o2,            32'd0);
        chk("ill_s3_err",  {31'd0, sel_err2},  32'd1);
        chk("ill_s3_vld",  {31'd0, out_valid2}, 32'd1);
        sel2 = 2'd1;
        tick();
        chk("ill_s1_data", data_o2,            CH1);
        chk("ill_s1_err",  {31'd0, sel_err2},  32'd1);
        sel2 = 2'd2;
        tick();
        chk("ill_s2_data", data_o2,            32'h0000_0025);
        chk("ill_s2_err",  {31'd0, sel_err2},  32'd1);

        in_valid2 = 1'b0; out_ready2 = 1'b0;
        for (int c = 0; c < 14; c++) tick();
        chk("sat_14", {28'd0, stall_cnt2}, 32'hE);
        for (int c = 0; c < 6; c++) tick();
        chk("sat_20",      {28'd0, stall_cnt2}, 32'hF);
        chk("sat_data",    data_o2,             32'h0000_0025);
        chk("sat_in_rdy",  {31'd0, in_ready2},  32'd0);

        // Both instances are stalled holding an operand; reset must drop it.
        reset = 1'b1;
        tick();
        chk("mid_rst_valid",  {31'd0, out_valid},  32'd0);
        chk("mid_rst_data",   data_o,              32'd0);
        chk("mid_rst_stall",  {16'd0, stall_cnt},  32'd0);
        chk("mid_rst_valid2", {31'd0, out_valid2}, 32'd0);
        chk("mid_rst_err2",   {31'd0, sel_err2},   32'd0);
        chk("mid_rst_stall2", {28'd0, stall_cnt2}, 32'd0);
        reset = 1'b0;

`ifdef ALU_OPSEL_SEXT_EN
        in_valid = 1'b1; out_ready = 1'b1; sel = 2'd2; sext = 1'b1;
        data = {CH3, 32'h0000_0025, CH1, CH0};
        tick();
        chk("sext_on",  data_o, 32'hFFFF_FFE5);
        sext = 1'b0;
        tick();
        chk("sext_off", data_o, 32'h0000_0025);
        sel = 2'd3; sext = 1'b1;
        tick();
        chk("sext_other", data_o, CH3);
        in_valid = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
